// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO: default geometry and pointer code conversions.
// The conversions take zero-extended operands, so they serve any pointer width up to PTR_MAXW.
package fifo_pkg;

  localparam int ADDRSIZE_DEF = 6;
  localparam int DSIZE_DEF    = 8;
  localparam int PTR_MAXW     = 32;

  typedef logic [PTR_MAXW-1:0] ptr_max_t;

  function automatic ptr_max_t bin2gray(input ptr_max_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic ptr_max_t gray2bin(input ptr_max_t gray);
    ptr_max_t bin;
    bin = '0;
    for (int i = 0; i < PTR_MAXW; i++) begin
      bin[i] = ^(gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_rd_obuf.sv
// Two-entry output buffer that absorbs the memory read latency in front of the consumer.
// Order is preserved; the issue logic upstream guarantees it is never pushed while full.
module fifo_rd_obuf
  import fifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             push_i,
  input  logic [DSIZE-1:0] push_data_i,
  input  logic             pop_i,
  output logic [1:0]       cnt_o,
  output logic [DSIZE-1:0] head_o
);

  logic [1:0][DSIZE-1:0] ent_q, ent_d;
  logic                  rd_idx_q, rd_idx_d;
  logic                  wr_idx_q, wr_idx_d;
  logic [1:0]            cnt_q, cnt_d;

  always_comb begin
    ent_d    = ent_q;
    rd_idx_d = rd_idx_q;
    wr_idx_d = wr_idx_q;
    cnt_d    = cnt_q;
    if (push_i) begin
      ent_d[wr_idx_q] = push_data_i;
      wr_idx_d        = ~wr_idx_q;
    end else begin
      wr_idx_d = wr_idx_q;
    end
    if (pop_i) begin
      rd_idx_d = ~rd_idx_q;
    end else begin
      rd_idx_d = rd_idx_q;
    end
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      ent_q    <= '0;
      rd_idx_q <= 1'b0;
      wr_idx_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      ent_q    <= ent_d;
      rd_idx_q <= rd_idx_d;
      wr_idx_q <= wr_idx_d;
      cnt_q    <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign head_o = ent_q[rd_idx_q];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller of the asynchronous FIFO: read pointers, memory read issue,
// first-word-fall-through output stream and empty/level status.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE      = ADDRSIZE_DEF,
  parameter int DSIZE         = DSIZE_DEF,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  output logic [ADDRSIZE:0]   rptr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic                mem_ren,
  input  logic [DSIZE-1:0]    mem_rdata,
  output logic [DSIZE-1:0]    rdata,
  output logic                rvalid,
  input  logic                rready,
  output logic                rempty,
  output logic                raempty,
  output logic [ADDRSIZE:0]   rlevel
);

  localparam int PW = ADDRSIZE + 1;
  typedef logic [PW-1:0] ptr_t;

  ptr_t       rbin_q, rbin_d;
  ptr_t       rptr_q, rptr_d;
  ptr_t       rlevel_q, rlevel_d;
  ptr_t       wbin_s;
  logic       inflight_q, inflight_d;
  logic       rempty_q, rempty_d;
  logic       raempty_q, raempty_d;
  logic [1:0] obuf_cnt_s, obuf_cnt_next_s;
  logic       avail_s, pop_s, ren_s, rvalid_s;
  logic [2:0] occ_s, budget_s;

  fifo_rd_obuf #(
    .DSIZE(DSIZE)
  ) u_obuf (
    .rclk       (rclk),
    .rrst_n     (rrst_n),
    .push_i     (inflight_q),
    .push_data_i(mem_rdata),
    .pop_i      (pop_s),
    .cnt_o      (obuf_cnt_s),
    .head_o     (rdata)
  );

  // A read may issue only if its word is guaranteed a buffer slot on arrival.
  always_comb begin
    wbin_s   = ptr_t'(gray2bin(ptr_max_t'(rq2_wptr)));
    avail_s  = (rbin_q != wbin_s);
    rvalid_s = (obuf_cnt_s != 2'd0);
    pop_s    = rvalid_s && rready;
    occ_s    = {1'b0, obuf_cnt_s} + {2'b00, inflight_q};
    budget_s = 3'd1 + {2'b00, pop_s};
    if (avail_s && (occ_s <= budget_s)) begin
      ren_s = 1'b1;
    end else begin
      ren_s = 1'b0;
    end
  end

  always_comb begin
    rbin_d     = rbin_q + ptr_t'(ren_s);
    rptr_d     = ptr_t'(bin2gray(ptr_max_t'(rbin_d)));
    inflight_d = ren_s;
    case ({inflight_q, pop_s})
      2'b10:   obuf_cnt_next_s = obuf_cnt_s + 2'd1;
      2'b01:   obuf_cnt_next_s = obuf_cnt_s - 2'd1;
      default: obuf_cnt_next_s = obuf_cnt_s;
    endcase
    rempty_d  = (rbin_d == wbin_s);
    // Level counts words still owed to the consumer, including buffered and in-flight ones.
    rlevel_d  = (wbin_s - rbin_d) + ptr_t'(obuf_cnt_next_s) + ptr_t'(inflight_d);
    raempty_d = (rlevel_d <= ptr_t'(AEMPTY_THRESH));
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_q     <= '0;
      rptr_q     <= '0;
      inflight_q <= 1'b0;
      rempty_q   <= 1'b1;
      raempty_q  <= 1'b1;
      rlevel_q   <= '0;
    end else begin
      rbin_q     <= rbin_d;
      rptr_q     <= rptr_d;
      inflight_q <= inflight_d;
      rempty_q   <= rempty_d;
      raempty_q  <= raempty_d;
      rlevel_q   <= rlevel_d;
    end
  end

  assign rptr    = rptr_q;
  assign raddr   = rbin_q[ADDRSIZE-1:0];
  assign mem_ren = ren_s;
  assign rvalid  = rvalid_s;
  assign rempty  = rempty_q;
  assign raempty = raempty_q;
  assign rlevel  = rlevel_q;

endmodule

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Read-domain controller for the asynchronous FIFO. It takes the Gray-coded write pointer after the two-stage synchronizer, keeps the binary and Gray read pointers, and issues read strobes and addresses to the dual-port memory. It hides the 1-cycle memory read latency behind a 2-entry output buffer, so consumers see a first-word-fall-through valid/ready stream. It also drives the empty, almost-empty and occupancy status used by read-side logic.

## Interface
- ADDRSIZE, 6, memory address width; pointers are ADDRSIZE+1 bits.
- DSIZE, 8, data word width.
- AEMPTY_THRESH, 4, raempty asserts when rlevel <= this value.

- rclk  in  1  read clock.
- rrst_n  in  1  reset, asynchronous, active-low.
- rq2_wptr  in  ADDRSIZE+1  Gray write pointer, already synchronized to rclk.
- rptr  out  ADDRSIZE+1  registered Gray read pointer, sent to the write-domain synchronizer.
- raddr  out  ADDRSIZE  memory read address; equals rbin[ADDRSIZE-1:0].
- mem_ren  out  1  memory read strobe (combinational).
- mem_rdata  in  DSIZE  memory read data, valid the cycle after mem_ren.
- rdata  out  DSIZE  head word of the output buffer.
- rvalid  out  1  rdata valid.
- rready  in  1  consumer accepts rdata.
- rempty  out  1  registered; storage empty as seen from the read domain.
- raempty  out  1  registered almost-empty.
- rlevel  out  ADDRSIZE+1  registered count of words not yet popped.

## Operation
- wbin = gray2bin(rq2_wptr), combinational.
- avail = (rbin != wbin).
- pop = rvalid && rready.
- Memory read issue:
  - mem_ren = avail && (obuf_cnt + inflight <= 1 + pop).
  - On mem_ren, rbin increments modulo 2^(ADDRSIZE+1), rptr <= bin2gray(rbin+1), and inflight <= 1. Otherwise inflight <= 0.
- Output buffer: 2-entry FIFO, obuf_cnt 0..2.
  - A cycle with inflight=1 writes mem_rdata into the buffer.
  - pop removes the head.
  - A push and a pop in the same cycle leave obuf_cnt unchanged.
  - The buffer preserves memory order.
- rvalid = (obuf_cnt != 0); rdata = head entry.
- rdata must stay stable while rvalid && !rready.
- Status registers, all updated from next-state values:
  - rempty <= (rbin_next == wbin).
  - rlevel <= (wbin - rbin_next) mod 2^(ADDRSIZE+1) + obuf_cnt_next + inflight_next.
  - raempty <= (rlevel_next <= AEMPTY_THRESH).
- Overflow is impossible by construction: obuf_cnt + inflight never exceeds 2. Any violation is a design bug and the bench must flag it.
- Reset state: rptr, raddr, rbin, obuf_cnt, inflight and rlevel = 0; rvalid = 0; mem_ren = 0; rempty = 1; raempty = 1; rdata = 0.
- Reset mid-operation discards the buffered and in-flight words. The write domain must be reset in the same event; this is a system requirement.

## Timing
- Word becomes visible:
  - rq2_wptr advances in cycle N (rbin == wbin before) → mem_ren in cycle N.
  - Buffer captures mem_rdata at the end of N+1.
  - rvalid is high in N+2, so the latency is 2 rclk.
- With rready held high and data available, sustained throughput is 1 word/cycle with no bubbles.
- rready low: at most 2 further mem_ren after the stall starts; the buffer plus in-flight word never exceed 2.
- rptr is registered and glitch-free. Only 1 bit changes per increment.
- Wrap-around: raddr wraps 2^ADDRSIZE-1 → 0 and the pointer MSB toggles. Empty detection uses the full ADDRSIZE+1-bit compare, so there is no false empty.
- A simultaneous rq2_wptr advance and last-word issue is handled by the combinational avail. The registered rempty may read 1 for one cycle even when avail is 1; this is the pessimistic direction and is acceptable.

## Structure
- fifo_pkg holds:
  - functions gray2bin and bin2gray, parameterized by width;
  - the ADDRSIZE default.
- One sub-module, fifo_rd_obuf: the 2-entry output buffer with push/pop, a count output and a head output.
- The pointer, issue logic and status registers stay in fifo_rd_ctrl.

## Test plan
- Reset: assert rrst_n=0 mid-stream → immediately rvalid=0, rptr=0, rempty=1, raempty=1, rlevel=0. After release with rq2_wptr=0, mem_ren stays 0.
- Single word: rq2_wptr 0→1 (Gray 0000001) at cycle N → mem_ren=1 with raddr=0 in N; rvalid=1 in N+2 with rdata=mem[0]; rptr=0000001; rempty=1 after the pop.
- Streaming: rq2_wptr=bin2gray(8), rready=1 → mem_ren on 8 consecutive cycles, rvalid continuous for 8 cycles with data mem[0..7] in order, final rptr=0001100, rempty=1.
- Backpressure: rq2_wptr=bin2gray(5), rready=0 → exactly 2 mem_ren, rptr=bin2gray(2), rlevel=5, raempty=0 (5 > 4). Then rready=1 → the remaining 3 words are read and all 5 are delivered in order; raempty=1 once rlevel<=4.
- Wrap: stream 130 words with a writer model → raddr 63→0 twice, the pointer MSB toggles, no false rempty while avail, and the data sequence is intact.
- Mid-burst reset: assert rrst_n during a stall with obuf_cnt=2 → the buffer is cleared. After release, the first rdata is the word at address 0 written after reset.
